stdp_update_sched: RTL and testbench

STDP_UPDATE_SCHED -- requirements
Module: stdp_update_sched

---
 rtl/stdp_update_sched_if.sv | 13 +
 rtl/stdp_update_sched.sv | 115 +++++++++++
 tb/tb_stdp_update_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_update_sched_if.sv
// Request bus from the STDP update scheduler to the shared weight-update datapath.
// The master side raises upd_valid and holds upd_chan/upd_dt until upd_ready is seen.
interface stdp_update_sched_if #(
    parameter int TW = 4
);
    logic          upd_valid;
    logic          upd_ready;
    logic [1:0]    upd_chan;
    logic [TW-1:0] upd_dt;

    modport master (output upd_valid, upd_chan, upd_dt, input upd_ready);
    modport slave  (input upd_valid, upd_chan, upd_dt, output upd_ready);
endinterface

// File: rtl/stdp_update_sched.sv
// STDP pair scheduler: per-channel pre-spike timers capture post-minus-pre dt on a
// post spike, and pending captures are issued round-robin over a valid/ready bus.
module stdp_update_sched #(
    parameter int NUM_PRE = 4,
    parameter int TW      = 4,
    parameter int WINDOW  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PRE-1:0]  pre_spike,
    input  logic                post_spike,
    stdp_update_sched_if.master upd,
    output logic [NUM_PRE-1:0]  pend,
    output logic                ovf,
    output logic                busy
);
    localparam int            CW   = 2;
    localparam logic [TW-1:0] TMAX = '1;
    localparam logic [TW:0]   WIN  = WINDOW[TW:0];

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic [TW-1:0] timer [NUM_PRE];
    logic [TW-1:0] dt    [NUM_PRE];
    logic [CW-1:0] last_grant;
    logic          upd_valid_r;
    logic [CW-1:0] upd_chan_r;
    logic [TW-1:0] upd_dt_r;

    logic [NUM_PRE-1:0] cap;
    logic [NUM_PRE-1:0] clr;
    logic [TW-1:0]      cap_dt [NUM_PRE];
    logic               grant_en;
    logic               found;
    logic [CW-1:0]      sel;
    logic [CW-1:0]      idx;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == TMAX) ? t : t + TW'(1);
    endfunction

    // Capture qualification and round-robin pick starting just after last_grant.
    always_comb begin
        cap      = '0;
        clr      = '0;
        found    = 1'b0;
        idx      = '0;
        sel      = last_grant + CW'(1);
        grant_en = (state == IDLE) && (pend != '0);
        for (int i = 0; i < NUM_PRE; i++) begin
            cap_dt[i] = pre_spike[i] ? '0 : timer[i];
            cap[i]    = post_spike &&
                        (pre_spike[i] || ((timer[i] != TMAX) && ({1'b0, timer[i]} < WIN)));
        end
        for (int k = 1; k <= NUM_PRE; k++) begin
            idx = last_grant + CW'(k);
            if (!found && pend[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        if (grant_en)
            clr[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRE; i++) begin
                timer[i] <= TMAX;
                dt[i]    <= '0;
            end
            pend        <= '0;
            ovf         <= 1'b0;
            state       <= IDLE;
            last_grant  <= CW'(3);
            upd_valid_r <= 1'b0;
            upd_chan_r  <= '0;
            upd_dt_r    <= '0;
        end else begin
            for (int i = 0; i < NUM_PRE; i++) begin
                timer[i] <= pre_spike[i] ? '0 : sat_inc(timer[i]);
                if (cap[i])
                    dt[i] <= cap_dt[i];
                // A capture beats a same-edge grant clear and is not an overrun.
                pend[i] <= cap[i] | (pend[i] & ~clr[i]);
                if (cap[i] && pend[i] && !clr[i])
                    ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        upd_chan_r  <= sel;
                        upd_dt_r    <= dt[sel];
                        upd_valid_r <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (upd.upd_ready) begin
                        upd_valid_r <= 1'b0;
                        last_grant  <= upd_chan_r;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign upd.upd_valid = upd_valid_r;
    assign upd.upd_chan  = upd_chan_r;
    assign upd.upd_dt    = upd_dt_r;
    assign busy          = (state != IDLE) || (pend != '0);
endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed bench for stdp_update_sched: table of single-pair captures plus
// hand-written sequences for round-robin, backpressure, overrun and reset.
module tb_stdp_update_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pre_spike = '0;
    logic       post_spike = 1'b0;
    logic [3:0] pend;
    logic       ovf;
    logic       busy;
    int         n_tests = 0;
    int         n_fail  = 0;

    stdp_update_sched_if #(.TW(4)) u_if ();

    stdp_update_sched #(.NUM_PRE(4), .TW(4), .WINDOW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .upd        (u_if),
        .pend       (pend),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int gap;
        bit req;
        int dt;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pre_spike = '0;
        post_spike = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int exp_dt[4];

    initial begin
        u_if.upd_ready = 1'b1;
        #1;
        check("rst_valid", {31'd0, u_if.upd_valid}, 0);
        check("rst_pend", {28'd0, pend}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_chan", {30'd0, u_if.upd_chan}, 0);
        check("rst_dt", {28'd0, u_if.upd_dt}, 0);

        // gap = edges from pre to post; dt = gap-1, or 0 when simultaneous
        vecs[0] = '{0, 4, 1'b1, 3};
        vecs[1] = '{2, 0, 1'b1, 0};
        vecs[2] = '{1, 9, 1'b0, 0};
        vecs[3] = '{1, 8, 1'b1, 7};
        vecs[4] = '{3, 1, 1'b1, 0};
        vecs[5] = '{2, 20, 1'b0, 0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            u_if.upd_ready = 1'b1;
            if (vecs[i].gap == 0) begin
                pre_spike = 4'(1 << vecs[i].ch);
                post_spike = 1'b1;
                step();
                pre_spike = '0;
                post_spike = 1'b0;
            end else begin
                pre_spike = 4'(1 << vecs[i].ch);
                step();
                pre_spike = '0;
                repeat (vecs[i].gap - 1) step();
                post_spike = 1'b1;
                step();
                post_spike = 1'b0;
            end
            check($sformatf("v%0d_pend", i), {28'd0, pend},
                  vecs[i].req ? 32'(1 << vecs[i].ch) : 32'd0);
            step();
            check($sformatf("v%0d_valid", i), {31'd0, u_if.upd_valid}, {31'd0, vecs[i].req});
            if (vecs[i].req) begin
                check($sformatf("v%0d_chan", i), {30'd0, u_if.upd_chan}, 32'(vecs[i].ch));
                check($sformatf("v%0d_dt", i), {28'd0, u_if.upd_dt}, 32'(vecs[i].dt));
            end
            step();
            check($sformatf("v%0d_valid_drop", i), {31'd0, u_if.upd_valid}, 0);
        end

        // Round-robin with distinct dts per channel
        do_reset();
        u_if.upd_ready = 1'b1;
        pre_spike = 4'b1000; step();
        pre_spike = 4'b0100; step();
        pre_spike = 4'b0010; step();
        pre_spike = 4'b0001; post_spike = 1'b1; step();
        pre_spike = '0; post_spike = 1'b0;
        check("rr_pend", {28'd0, pend}, 32'hf);
        exp_dt = '{0, 0, 1, 2};
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("rr%0d_valid", j), {31'd0, u_if.upd_valid}, 1);
            check($sformatf("rr%0d_chan", j), {30'd0, u_if.upd_chan}, 32'(j));
            check($sformatf("rr%0d_dt", j), {28'd0, u_if.upd_dt}, 32'(exp_dt[j]));
            step();
            check($sformatf("rr%0d_gap", j), {31'd0, u_if.upd_valid}, 0);
        end
        check("rr_busy_end", {31'd0, busy}, 0);

        // Backpressure with a new capture on the in-flight channel
        do_reset();
        u_if.upd_ready = 1'b0;
        pre_spike = 4'b0001; step();
        pre_spike = '0; step(); step();
        post_spike = 1'b1; step();
        post_spike = 1'b0;
        step();
        check("bp_valid0", {31'd0, u_if.upd_valid}, 1);
        check("bp_busy", {31'd0, busy}, 1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                pre_spike = 4'b0001;
                post_spike = 1'b1;
            end
            step();
            pre_spike = '0;
            post_spike = 1'b0;
            check($sformatf("bp%0d_valid", k), {31'd0, u_if.upd_valid}, 1);
            check($sformatf("bp%0d_chan", k), {30'd0, u_if.upd_chan}, 0);
            check($sformatf("bp%0d_dt", k), {28'd0, u_if.upd_dt}, 2);
            if (k == 1) begin
                check("bp_repend", {28'd0, pend}, 1);
                check("bp_no_ovf", {31'd0, ovf}, 0);
            end
        end
        u_if.upd_ready = 1'b1;
        step();
        check("bp_hs_valid", {31'd0, u_if.upd_valid}, 0);
        step();
        check("bp_re_valid", {31'd0, u_if.upd_valid}, 1);
        check("bp_re_chan", {30'd0, u_if.upd_chan}, 0);
        check("bp_re_dt", {28'd0, u_if.upd_dt}, 0);

        // Capture and grant-clear on the same channel at the same edge
        do_reset();
        u_if.upd_ready = 1'b1;
        pre_spike = 4'b0001; post_spike = 1'b1; step();
        step();
        pre_spike = '0; post_spike = 1'b0;
        check("cw_valid", {31'd0, u_if.upd_valid}, 1);
        check("cw_pend", {28'd0, pend}, 1);
        check("cw_ovf", {31'd0, ovf}, 0);

        // Overrun on channel 3 while channel 0 is stalled in flight
        do_reset();
        u_if.upd_ready = 1'b0;
        pre_spike = 4'b0001; step();
        pre_spike = '0;
        repeat (6) step();
        post_spike = 1'b1; step();
        post_spike = 1'b0;
        pre_spike = 4'b1000; step();
        pre_spike = '0;
        check("ov_blk_chan", {30'd0, u_if.upd_chan}, 0);
        check("ov_blk_dt", {28'd0, u_if.upd_dt}, 6);
        step(); step();
        post_spike = 1'b1; step();
        post_spike = 1'b0;
        check("ov_first_pend", {28'd0, pend}, 32'h8);
        check("ov_first_ovf", {31'd0, ovf}, 0);
        step(); step();
        post_spike = 1'b1; step();
        post_spike = 1'b0;
        check("ov_set", {31'd0, ovf}, 1);
        check("ov_pend", {28'd0, pend}, 32'h8);
        u_if.upd_ready = 1'b1;
        step();
        check("ov_hs_valid", {31'd0, u_if.upd_valid}, 0);
        step();
        check("ov_req_valid", {31'd0, u_if.upd_valid}, 1);
        check("ov_req_chan", {30'd0, u_if.upd_chan}, 3);
        check("ov_req_dt", {28'd0, u_if.upd_dt}, 5);
        repeat (3) step();
        check("ov_sticky", {31'd0, ovf}, 1);
        rst_n = 1'b0;
        #1;
        check("ov_rst_clear", {31'd0, ovf}, 0);
        step();

        // Reset during ISSUE abandons the request
        do_reset();
        u_if.upd_ready = 1'b0;
        pre_spike = 4'b0011; post_spike = 1'b1; step();
        pre_spike = '0; post_spike = 1'b0;
        step();
        check("mr_valid_pre", {31'd0, u_if.upd_valid}, 1);
        check("mr_pend_pre", {28'd0, pend}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, u_if.upd_valid}, 0);
        check("mr_pend", {28'd0, pend}, 0);
        check("mr_busy", {31'd0, busy}, 0);
        step();
        rst_n = 1'b1;
        u_if.upd_ready = 1'b1;
        // Saturated timers must not capture a lone post spike
        post_spike = 1'b1; step();
        post_spike = 1'b0;
        check("mr_sat_pend", {28'd0, pend}, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("mr_idle%0d", k), {31'd0, u_if.upd_valid}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
